// File: rtl/div_pkg.sv
// Shared types for the sequential divide functional unit.
package div_pkg;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
    } Crf_t;

    // Condition field from the sign/zero of a result plus the summary-overflow bit.
    function automatic Crf_t make_crf(input logic neg, input logic zero, input logic so);
        Crf_t c;
        c.lt = neg;
        c.gt = !neg && !zero;
        c.eq = zero;
        c.so = so;
        return c;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring divide iteration retiring BITS_PER_CYCLE quotient bits.
module div_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH+1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH+1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] r;
    logic [WIDTH+1:0] d;
    logic [WIDTH-1:0] q;

    // The dividend shifts out of the quotient register into the partial remainder;
    // a negative remainder adds the divisor back instead of subtracting it.
    always_comb begin
        d = {2'b00, divisor};
        r = rem_in;
        q = quo_in;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r[WIDTH+1])
                r = {r[WIDTH:0], q[WIDTH-1]} + d;
            else
                r = {r[WIDTH:0], q[WIDTH-1]} - d;
            q = {q[WIDTH-2:0], ~r[WIDTH+1]};
        end
        rem_out = r;
        quo_out = q;
    end

endmodule

// File: rtl/fub_div_seq.sv
// Iterative signed/unsigned divide and modulo unit with thread-tagged flush and
// early-out for divide-by-zero and signed overflow.
module fub_div_seq
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int THREAD_W       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_uns,
    input  logic                in_rem,
    input  logic                in_oe,
    input  logic                in_so,
    input  logic [THREAD_W-1:0] in_thread,
    input  logic                flush,
    input  logic [THREAD_W-1:0] flush_thread,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_result,
    output logic [3:0]          out_crf,
    output logic                out_ov,
    output logic [THREAD_W-1:0] out_thread
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t              state;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    res;
    logic [WIDTH+1:0]    rem;
    logic                uns;
    logic                rem_op;
    logic                oe;
    logic                so;
    logic                ov;
    logic                neg_q;
    logic                neg_r;
    logic [THREAD_W-1:0] thread;

    logic [WIDTH+1:0]    rem_step;
    logic [WIDTH-1:0]    quo_step;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [WIDTH-1:0]    r_fix;
    logic [WIDTH-1:0]    fix_val;
    logic                special;
    logic                kill;

    assign in_ready = (state == IDLE);
    assign kill     = flush && (flush_thread == thread) && (state != IDLE);

    div_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (b_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // b_reg holds the raw divisor in PREP and its magnitude from ITER onwards.
    always_comb begin
        a_mag   = (!uns && a_reg[WIDTH-1]) ? -a_reg : a_reg;
        b_mag   = (!uns && b_reg[WIDTH-1]) ? -b_reg : b_reg;
        special = (b_reg == '0) || (!uns && a_reg == MIN_VAL && b_reg == '1);
        r_fix   = rem[WIDTH+1] ? rem[WIDTH-1:0] + b_reg : rem[WIDTH-1:0];
        if (rem_op)
            fix_val = neg_r ? -r_fix : r_fix;
        else
            fix_val = neg_q ? -quo : quo;
    end

    // Result outputs are zero whenever no pulse is being delivered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            quo        <= '0;
            res        <= '0;
            rem        <= '0;
            uns        <= 1'b0;
            rem_op     <= 1'b0;
            oe         <= 1'b0;
            so         <= 1'b0;
            ov         <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            thread     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_crf    <= '0;
            out_ov     <= 1'b0;
            out_thread <= '0;
        end else begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_crf    <= '0;
            out_ov     <= 1'b0;
            if (kill) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            a_reg  <= in_a;
                            b_reg  <= in_b;
                            uns    <= in_uns;
                            rem_op <= in_rem;
                            oe     <= in_oe;
                            so     <= in_so;
                            thread <= in_thread;
                            state  <= PREP;
                        end
                    end
                    PREP: begin
                        quo   <= a_mag;
                        b_reg <= b_mag;
                        rem   <= '0;
                        neg_q <= !uns && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                        neg_r <= !uns && a_reg[WIDTH-1];
                        count <= CW'(ITERS);
                        ov    <= special;
                        res   <= '0;
                        state <= special ? DONE : ITER;
                    end
                    ITER: begin
                        rem   <= rem_step;
                        quo   <= quo_step;
                        count <= count - CW'(1);
                        if (count == CW'(1))
                            state <= FIX;
                    end
                    FIX: begin
                        res   <= fix_val;
                        state <= DONE;
                    end
                    DONE: begin
                        out_valid  <= 1'b1;
                        out_result <= res;
                        out_ov     <= ov;
                        out_crf    <= make_crf(res[WIDTH-1], res == '0, so | (ov & oe));
                        out_thread <= thread;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fub_div_seq.sv
// Randomised self-checking bench for fub_div_seq against an arithmetic reference model.
module tb_fub_div_seq;

    localparam int BPC   = 1;
    localparam int ITERS = 32 / BPC;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_uns;
    logic        in_rem;
    logic        in_oe;
    logic        in_so;
    logic [1:0]  in_thread;
    logic        flush;
    logic [1:0]  flush_thread;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_crf;
    logic        out_ov;
    logic [1:0]  out_thread;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  crf;
        logic        ov;
        logic [1:0]  thr;
        int          due;
    } exp_t;

    exp_t expq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    fub_div_seq #(
        .WIDTH          (32),
        .BITS_PER_CYCLE (BPC),
        .THREAD_W       (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_uns       (in_uns),
        .in_rem       (in_rem),
        .in_oe        (in_oe),
        .in_so        (in_so),
        .in_thread    (in_thread),
        .flush        (flush),
        .flush_thread (flush_thread),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_crf      (out_crf),
        .out_ov       (out_ov),
        .out_thread   (out_thread)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer division; due holds latency until the driver adds the accept cycle.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                   input logic rem, input logic oe, input logic so,
                                   input logic [1:0] thr);
        exp_t e;
        e.thr = thr;
        e.ov  = 1'b0;
        e.res = '0;
        e.due = ITERS + 3;
        if (b == 0 || (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            e.ov  = 1'b1;
            e.due = 2;
        end else if (uns) begin
            if (rem) e.res = a % b;
            else     e.res = a / b;
        end else begin
            if (rem) e.res = $signed(a) % $signed(b);
            else     e.res = $signed(a) / $signed(b);
        end
        e.crf = {$signed(e.res) < 0, $signed(e.res) > 0, e.res == 0, so | (e.ov & oe)};
        return e;
    endfunction

    // Every cycle: either the due result is on the outputs, or they are all quiet.
    always @(negedge clk) begin
        if (expq.size() > 0 && cyc == expq[0].due) begin
            check_output("valid",  out_valid,  1);
            check_output("result", out_result, expq[0].res);
            check_output("crf",    out_crf,    expq[0].crf);
            check_output("ov",     out_ov,     expq[0].ov);
            check_output("thread", out_thread, expq[0].thr);
            void'(expq.pop_front());
        end else begin
            check_output("quiet", {out_valid, out_ov, out_crf, out_result}, 0);
        end
    end

    // Offers an op from a negedge and returns at the negedge after the accepting edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                  input logic rem, input logic oe, input logic so,
                                  input logic [1:0] thr, input logic hold, output int acc);
        exp_t e;
        int   n;
        in_a = a; in_b = b; in_uns = uns; in_rem = rem;
        in_oe = oe; in_so = so; in_thread = thr; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("accept");
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc   = cyc + 1;
        e     = model(a, b, uns, rem, oe, so, thr);
        e.due = acc + e.due;
        expq.push_back(e);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic do_flush(input int acc, input int off, input logic [1:0] thr);
        logic killed;
        int   n;
        n = 0;
        while (cyc < acc + off && n < 1000) begin
            @(negedge clk);
            n++;
        end
        flush = 1'b1;
        flush_thread = thr;
        killed = expq.size() > 0 && expq[$].thr == thr && expq[$].due > cyc;
        if (killed) void'(expq.pop_back());
        @(negedge clk);
        flush = 1'b0;
        if (killed) check_output("flush_ready", in_ready, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((expq.size() > 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() > 0 || !in_ready) begin
            timeout_fail("idle");
            expq.delete();
        end
    endtask

    initial begin
        exp_t        m;
        int          acc;
        int          acc2;
        int          lat1;
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  thr;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_uns = 1'b0;
        in_rem = 1'b0; in_oe = 1'b0; in_so = 1'b0; in_thread = '0;
        flush = 1'b0; flush_thread = '0;
        repeat (3) @(negedge clk);
        check_output("reset_ready",  in_ready,   1);
        check_output("reset_thread", out_thread, 0);
        reset = 1'b0;
        @(negedge clk);

        m = model(32'd100, 32'd7, 1, 0, 0, 0, 0);
        check_output("model_100_7", {m.res, m.crf, m.ov}, {32'd14, 4'b0100, 1'b0});
        m = model(32'hFFFF_FF9C, 32'd7, 0, 0, 0, 0, 0);
        check_output("model_m100_7", {m.res, m.crf}, {32'hFFFF_FFF2, 4'b1000});
        m = model(32'hFFFF_FF9C, 32'd7, 0, 1, 0, 0, 0);
        check_output("model_m100_rem7", m.res, 32'hFFFF_FFFE);
        m = model(32'd5, 32'd0, 1, 0, 1, 0, 0);
        check_output("model_div0_oe", {m.res, m.crf, m.ov}, {32'd0, 4'b0011, 1'b1});
        m = model(32'd5, 32'd0, 1, 0, 0, 0, 0);
        check_output("model_div0", {m.crf, m.ov}, {4'b0010, 1'b1});

        apply_stimulus(32'd100, 32'd7, 1, 0, 0, 0, 2'd0, 0, acc);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("lat_100_7", cyc - acc, (BPC == 1) ? 35 : 19);
        wait_idle();

        apply_stimulus(32'hFFFF_FF9C, 32'd7, 0, 0, 0, 0, 2'd1, 0, acc); wait_idle();
        apply_stimulus(32'hFFFF_FF9C, 32'd7, 0, 1, 0, 0, 2'd2, 0, acc); wait_idle();
        apply_stimulus(32'd5, 32'd0, 1, 0, 1, 0, 2'd3, 0, acc);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("lat_div0", cyc - acc, 2);
        wait_idle();
        apply_stimulus(32'd5, 32'd0, 1, 0, 0, 0, 2'd0, 0, acc); wait_idle();
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 0, 2'd1, 0, acc); wait_idle();
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1, 0, 2'd1, 0, acc); wait_idle();
        apply_stimulus(32'h8000_0000, 32'd3, 0, 1, 0, 1, 2'd2, 0, acc); wait_idle();

        apply_stimulus(32'd1000, 32'd9, 1, 0, 0, 0, 2'd1, 0, acc);
        check_output("busy_not_ready", in_ready, 0);
        do_flush(acc, 10, 2'd1);
        wait_idle();
        apply_stimulus(32'd1000, 32'd9, 1, 0, 0, 0, 2'd1, 0, acc);
        do_flush(acc, 10, 2'd2);
        wait_idle();
        apply_stimulus(32'd1000, 32'd9, 1, 1, 0, 0, 2'd3, 0, acc);
        do_flush(acc, ITERS + 2, 2'd3);
        wait_idle();

        flush = 1'b1; flush_thread = 2'd2;
        apply_stimulus(32'd77, 32'd5, 1, 0, 0, 0, 2'd2, 0, acc);
        flush = 1'b0;
        wait_idle();

        apply_stimulus(32'd100, 32'd7, 1, 0, 0, 0, 2'd1, 1, acc);
        lat1 = expq[$].due - acc;
        check_output("b2b_busy", in_ready, 0);
        apply_stimulus(32'hFFFF_FF9C, 32'd7, 0, 1, 1, 1, 2'd2, 0, acc2);
        check_output("b2b_accept", acc2, acc + lat1 + 1);
        wait_idle();

        apply_stimulus(32'd12345, 32'd11, 1, 0, 0, 0, 2'd0, 0, acc);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        expq.delete();
        @(negedge clk);
        check_output("midop_reset_ready", in_ready, 1);
        reset = 1'b0;
        repeat (ITERS + 5) @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300) - 150; b = $urandom_range(1, 20) - 10; end
                3: begin a = $urandom; b = $urandom_range(1, 50); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            thr = 2'($urandom_range(0, 3));
            apply_stimulus(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), thr, 0, acc);
            if ($urandom_range(0, 3) == 0)
                do_flush(acc, $urandom_range(0, ITERS + 5), 2'($urandom_range(0, 3)));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
